// File: rtl/pipeline_pkg.sv
// Shared hazard-control types and constants for the pipeline.
// The optional performance counters are enabled by HAZARD_PERF_CNT_EN.
package pipeline_pkg;

   localparam int REG_ADDR_W      = 5;
   localparam int MEM_TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hz_state_e;

endpackage

// File: rtl/hazard_raw_detect.sv
// Read-after-write comparator for the instruction in D against EX and M.
// Writeback is not compared: the register file is write-first.
module hazard_raw_detect
   import pipeline_pkg::*;
(
   input  logic [REG_ADDR_W-1:0] rs1_i,
   input  logic [REG_ADDR_W-1:0] rs2_i,
   input  logic                  rs1_used_i,
   input  logic                  rs2_used_i,
   input  logic [REG_ADDR_W-1:0] rd_ex_i,
   input  logic                  we_ex_i,
   input  logic [REG_ADDR_W-1:0] rd_m_i,
   input  logic                  we_m_i,
   output logic                  raw_o
);

   logic rs1_live;
   logic rs2_live;
   logic hit_ex;
   logic hit_m;

   // x0 is hardwired to zero, so it never carries a dependency
   assign rs1_live = rs1_used_i && (rs1_i != '0);
   assign rs2_live = rs2_used_i && (rs2_i != '0);

   assign hit_ex = we_ex_i &&
                   ((rs1_live && (rd_ex_i == rs1_i)) ||
                    (rs2_live && (rd_ex_i == rs2_i)));

   assign hit_m  = we_m_i &&
                   ((rs1_live && (rd_m_i == rs1_i)) ||
                    (rs2_live && (rd_m_i == rs2_i)));

   assign raw_o = hit_ex || hit_m;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush controller with data-memory timeout watchdog.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [REG_ADDR_W-1:0] rs1_D,
   input  logic [REG_ADDR_W-1:0] rs2_D,
   input  logic                  rs1_used_D,
   input  logic                  rs2_used_D,
   input  logic [REG_ADDR_W-1:0] rd_EX,
   input  logic                  reg_write_EX,
   input  logic [REG_ADDR_W-1:0] rd_M,
   input  logic                  reg_write_M,
   input  logic                  pc_sel_EX,
   input  logic                  mem_req_M,
   input  logic                  mem_ready_M,
   output logic                  stall_F,
   output logic                  stall_D,
   output logic                  stall_E,
   output logic                  stall_M,
   output logic                  flush_D,
   output logic                  flush_E,
   output logic                  flush_W,
   output logic                  err_o,
   output logic [CNT_W-1:0]      stall_cnt_o,
   output logic [CNT_W-1:0]      flush_cnt_o
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   hz_state_e         state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              raw;
   logic              mem_busy;

   hazard_raw_detect u_raw (
      .rs1_i      (rs1_D),
      .rs2_i      (rs2_D),
      .rs1_used_i (rs1_used_D),
      .rs2_used_i (rs2_used_D),
      .rd_ex_i    (rd_EX),
      .we_ex_i    (reg_write_EX),
      .rd_m_i     (rd_M),
      .we_m_i     (reg_write_M),
      .raw_o      (raw)
   );

   assign mem_busy = mem_req_M && !mem_ready_M;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // wait_q counts busy cycles including the one that left RUN
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      unique case (state_q)
         RUN: begin
            if (mem_busy) begin
               state_d = MEM_WAIT;
               wait_d  = WAIT_W'(1);
            end else begin
               wait_d  = '0;
            end
         end
         MEM_WAIT: begin
            if (!mem_busy) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_q == WAIT_LAST) begin
               state_d = ERROR;
            end else begin
               wait_d  = wait_q + WAIT_W'(1);
            end
         end
         ERROR: begin
            state_d = ERROR;
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
   end

   always_comb begin
      stall_F = 1'b0;
      stall_D = 1'b0;
      stall_E = 1'b0;
      stall_M = 1'b0;
      flush_D = 1'b0;
      flush_E = 1'b0;
      flush_W = 1'b0;
      if (!rst_ni) begin
         stall_F = 1'b0;
      end else if (state_q == ERROR) begin
         stall_F = 1'b1;
         stall_D = 1'b1;
         stall_E = 1'b1;
         stall_M = 1'b1;
      end else if (mem_busy) begin
         // a taken branch stays parked in D_E until memory completes
         stall_F = 1'b1;
         stall_D = 1'b1;
         stall_E = 1'b1;
         stall_M = 1'b1;
         flush_W = 1'b1;
      end else if (pc_sel_EX) begin
         flush_D = 1'b1;
         flush_E = 1'b1;
      end else if (raw) begin
         stall_F = 1'b1;
         stall_D = 1'b1;
         flush_E = 1'b1;
      end
   end

   assign err_o = (state_q == ERROR);

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall_F && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_D && !(&flush_cnt_q)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, max cycles one data-memory access may stall before error.
REQ-002 SHALL have parameter CNT_W, default 32, performance counter width.
REQ-003 SHALL have one clock, clk_i; reset is rst_ni, asynchronous, active-low.
REQ-004 clk_i  in  1  pipeline clock.
REQ-005 rst_ni  in  1  async active-low reset.
REQ-006 rs1_D, rs2_D  in  5  source registers of the instruction in D.
REQ-007 rs1_used_D, rs2_used_D  in  1  source actually read.
REQ-008 rd_EX, reg_write_EX  in  5/1  destination and write-enable in EX.
REQ-009 rd_M, reg_write_M  in  5/1  destination and write-enable in M.
REQ-010 pc_sel_EX  in  1  branch/jump taken in EX.
REQ-011 mem_req_M, mem_ready_M  in  1/1  data-memory request and completion in M.
REQ-012 stall_F, stall_D, stall_E, stall_M  out  1  hold PC, F_D, D_E, E_M registers.
REQ-013 flush_D, flush_E, flush_W  out  1  bubble into F_D, D_E, M_W registers.
REQ-014 err_o  out  1  sticky memory-timeout error.
REQ-015 stall_cnt_o, flush_cnt_o  out  CNT_W  stall / branch-flush cycle counts.

Function
REQ-016 raw = (rsX_used_D & rsX_D!=0 & reg_write_Y & rd_Y==rsX_D) for X in {1,2}, Y in {EX,M}; WB not compared (write-first register file).
REQ-017 mem_busy = mem_req_M & !mem_ready_M.
REQ-018 Priority, highest first: ERROR, mem_busy, pc_sel_EX, raw.
REQ-019 ERROR: all stall_* =1, all flush_* =0.
REQ-020 mem_busy: stall_F/D/E/M=1, flush_W=1, flush_D=flush_E=0; a pending pc_sel_EX is held in D_E and acted on in the first non-busy cycle.
REQ-021 pc_sel_EX (no mem_busy): flush_D=flush_E=1, stalls 0; raw ignored (wrong-path instruction).
REQ-022 raw only: stall_F=stall_D=1, flush_E=1, all else 0.
REQ-023 None active: all stall_*/flush_* =0.
REQ-024 stall_*/flush_* combinational from state and inputs; zero latency.
REQ-025 FSM states RUN, MEM_WAIT, ERROR; RUN->MEM_WAIT on mem_busy; MEM_WAIT->RUN when !mem_busy; MEM_WAIT->ERROR when wait counter reaches MEM_TIMEOUT-1 with mem_busy still 1; ERROR exits only by reset.
REQ-026 Wait counter: cleared on RUN entry, increments each MEM_WAIT cycle, width $clog2(MEM_TIMEOUT)+1.
REQ-027 mem_req_M dropped while waiting SHALL return to RUN (no error).
REQ-028 err_o =1 exactly while state is ERROR.

Reset
REQ-029 rst_ni low: state=RUN, wait counter=0, err_o=0, counters=0, all stall_*/flush_* forced 0 regardless of inputs.
REQ-030 Reset mid-MEM_WAIT or in ERROR SHALL return to RUN immediately, no clock needed.

Configuration
REQ-031 Macro HAZARD_PERF_CNT_EN defined: stall_cnt_o increments each cycle stall_F=1; flush_cnt_o increments each cycle flush_D=1; both saturate at all-ones.
REQ-032 Macro undefined: ports stall_cnt_o/flush_cnt_o remain, tied to 0, no counter flops.

Structure
REQ-033 Shared package pipeline_pkg holds hz_state_e enum (RUN, MEM_WAIT, ERROR), REG_ADDR_W=5 and default MEM_TIMEOUT constant.
REQ-034 One sub-module, hazard_raw_detect: purely combinational raw comparator per REQ-016.

Verification
REQ-035 rs1_D=5, rs1_used_D=1, rd_EX=5, reg_write_EX=1 -> stall_F=stall_D=flush_E=1; same with rs1_D=0 -> all 0.
REQ-036 raw active plus pc_sel_EX=1 -> flush_D=flush_E=1, stall_F=0; stall_cnt unchanged, flush_cnt+1 (macro on).
REQ-037 mem_req_M=1, mem_ready_M=0 for 3 cycles, then ready -> stall_F/D/E/M=flush_W=1 for 3 cycles, state RUN after, err_o=0.
REQ-038 mem_busy for 16 cycles with MEM_TIMEOUT=16 -> err_o=1 from cycle 17, all stalls held; rst_ni pulse -> err_o=0, outputs 0 asynchronously.
REQ-039 mem_busy with pc_sel_EX=1 for 2 cycles, then ready -> flush_D=0 while busy, flush_D=flush_E=1 first ready cycle.
REQ-040 CNT_W=4, macro on, raw held 20 cycles -> stall_cnt_o saturates at 15; macro off -> stall_cnt_o=0.
